chacha_block_core: RTL and testbench

CHACHA_BLOCK_CORE -- requirements
Module: chacha_block_core

---
 rtl/chacha_block_core.sv | 191 +++++++++++++++++++
 tb/tb_chacha_block_core.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/chacha_block_core.sv
// Iterative ChaCha block function: LANES quarter-rounds per cycle, then feed-forward add.
// Optional macro CHACHA_CTR_AUTOINC_EN adds next_blk/ctr_wrap for block-counter auto-increment.
module chacha_block_core #(
   parameter int ROUNDS = 20,
   parameter int LANES  = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [511:0] state_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [511:0] state_out,
   output logic         busy
`ifdef CHACHA_CTR_AUTOINC_EN
   ,
   input  logic         next_blk,
   output logic         ctr_wrap
`endif
);

   if (!((ROUNDS >= 2) && (ROUNDS <= 20) && ((ROUNDS % 2) == 0)) ||
       !((LANES == 1) || (LANES == 2) || (LANES == 4))) begin : g_bad_cfg
      $error("chacha_block_core: illegal ROUNDS/LANES configuration");
   end

   localparam logic [4:0] DR_LAST = 5'(ROUNDS / 2);

   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_ADD, S_DONE} state_t;

   state_t       r_state, w_state_nxt;
   logic [31:0]  r_init [16];
   logic [31:0]  r_work [16];
   logic [31:0]  w_round [16];
   logic [31:0]  w_load [16];
   logic [2:0]   r_qr_idx;
   logic [4:0]   r_dr_cnt;
   logic [3:0]   w_qr_nxt;
   logic         w_wrap;
   logic         w_start;
   logic         w_auto;
   logic [2:0]   w_grp;
   logic [127:0] w_qr;
   logic [511:0] r_state_out;
   logic         r_in_ready, r_out_valid, r_busy;

   function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   function automatic logic [127:0] quarter_round(input logic [31:0] a_in, input logic [31:0] b_in,
                                                  input logic [31:0] c_in, input logic [31:0] d_in);
      logic [31:0] a, b, c, d;
      a = a_in; b = b_in; c = c_in; d = d_in;
      a = a + b; d = rotl(d ^ a, 16);
      c = c + d; b = rotl(b ^ c, 12);
      a = a + b; d = rotl(d ^ a, 8);
      c = c + d; b = rotl(b ^ c, 7);
      return {a, b, c, d};
   endfunction

   // Word index of element k of group g: columns keep the column, diagonals shift it by the row.
   function automatic logic [3:0] grp_idx(input logic [2:0] g, input logic [1:0] k);
      logic [1:0] col;
      if (g[2]) col = g[1:0] + k;
      else      col = g[1:0];
      return {k, col};
   endfunction

   // Start decision and the state to load (fresh input, or stored init with counter bumped).
   always_comb begin
      w_start = 1'b0;
      w_auto  = 1'b0;
      for (int i = 0; i < 16; i++) w_load[i] = state_in[32*i +: 32];
      if (r_state == S_IDLE) begin
         if (in_valid) begin
            w_start = 1'b1;
         end else begin
`ifdef CHACHA_CTR_AUTOINC_EN
            w_start = next_blk;
            w_auto  = next_blk;
`else
            w_start = 1'b0;
`endif
         end
      end else begin
         w_start = 1'b0;
      end
      if (w_auto) begin
         for (int i = 0; i < 16; i++) w_load[i] = r_init[i];
         w_load[12] = r_init[12] + 32'd1;
      end else begin
         w_auto = 1'b0;
      end
   end

   // LANES disjoint quarter-rounds on the current groups of the working state.
   always_comb begin
      w_round = r_work;
      w_grp   = 3'd0;
      w_qr    = 128'd0;
      for (int l = 0; l < LANES; l++) begin
         w_grp = r_qr_idx + 3'(l);
         w_qr  = quarter_round(r_work[grp_idx(w_grp, 2'd0)], r_work[grp_idx(w_grp, 2'd1)],
                               r_work[grp_idx(w_grp, 2'd2)], r_work[grp_idx(w_grp, 2'd3)]);
         w_round[grp_idx(w_grp, 2'd0)] = w_qr[127:96];
         w_round[grp_idx(w_grp, 2'd1)] = w_qr[95:64];
         w_round[grp_idx(w_grp, 2'd2)] = w_qr[63:32];
         w_round[grp_idx(w_grp, 2'd3)] = w_qr[31:0];
      end
   end

   assign w_qr_nxt = {1'b0, r_qr_idx} + 4'(LANES);
   assign w_wrap   = (w_qr_nxt == 4'd8);

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_state_nxt = S_ROUND; else w_state_nxt = S_IDLE;
         S_ROUND: if (w_wrap && ((r_dr_cnt + 5'd1) == DR_LAST)) w_state_nxt = S_ADD;
                  else w_state_nxt = S_ROUND;
         S_ADD:   w_state_nxt = S_DONE;
         S_DONE:  if (out_ready) w_state_nxt = S_IDLE; else w_state_nxt = S_DONE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register with handshake/status outputs registered alongside it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= (w_state_nxt == S_IDLE);
         r_out_valid <= (w_state_nxt == S_DONE);
         r_busy      <= (w_state_nxt != S_IDLE);
      end
   end

   // Datapath: capture, round iteration, and feed-forward addition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            r_init[i] <= 32'd0;
            r_work[i] <= 32'd0;
         end
         r_qr_idx    <= 3'd0;
         r_dr_cnt    <= 5'd0;
         r_state_out <= 512'd0;
      end else begin
         case (r_state)
            S_IDLE: if (w_start) begin
               r_init   <= w_load;
               r_work   <= w_load;
               r_qr_idx <= 3'd0;
               r_dr_cnt <= 5'd0;
            end
            S_ROUND: begin
               r_work   <= w_round;
               r_qr_idx <= w_wrap ? 3'd0 : w_qr_nxt[2:0];
               if (w_wrap) r_dr_cnt <= r_dr_cnt + 5'd1;
            end
            S_ADD: for (int i = 0; i < 16; i++) r_state_out[32*i +: 32] <= r_work[i] + r_init[i];
            default: ;
         endcase
      end
   end

`ifdef CHACHA_CTR_AUTOINC_EN
   logic r_ctr_wrap;

   // One-cycle pulse when the auto-incremented counter rolls over to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ctr_wrap <= 1'b0;
      else        r_ctr_wrap <= w_auto && (r_init[12] == 32'hFFFF_FFFF);
   end

   assign ctr_wrap = r_ctr_wrap;
`endif

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign state_out = r_state_out;

endmodule

// File: tb/tb_chacha_block_core.sv
// Bench for chacha_block_core: three instances (LANES 1/2/4, ROUNDS 20) share one stimulus stream.
// Known-answer table, random blocks against a reference model, backpressure, mid-round reset, counter auto-increment.
module tb_chacha_block_core;
   localparam int ROUNDS = 20;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         out_ready;
   logic [511:0] state_in;
   logic [2:0]   in_ready, out_valid, busy;
   logic [511:0] state_out [3];
`ifdef CHACHA_CTR_AUTOINC_EN
   logic         next_blk;
   logic [2:0]   ctr_wrap;
`endif
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      chacha_block_core #(.ROUNDS(ROUNDS), .LANES(1 << k)) u_dut (
         .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[k]),
         .state_in(state_in), .out_valid(out_valid[k]), .out_ready(out_ready),
         .state_out(state_out[k]), .busy(busy[k])
`ifdef CHACHA_CTR_AUTOINC_EN
         , .next_blk(next_blk), .ctr_wrap(ctr_wrap[k])
`endif
      );
   end

   typedef struct {
      logic [511:0] st;
      logic [31:0]  w0;
      logic [31:0]  w1;
   } vec_t;

   function automatic logic [31:0] rl(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   // Reference ChaCha block: ROUNDS/2 double rounds over explicit column/diagonal lists, then add.
   function automatic logic [511:0] chacha_ref(input logic [511:0] st);
      logic [31:0]  x [16];
      int           t [8][4];
      logic [31:0]  a, b, c, d;
      logic [511:0] r;
      t = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
            '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
      for (int i = 0; i < 16; i++) x[i] = st[32*i +: 32];
      for (int dr = 0; dr < ROUNDS / 2; dr++) begin
         for (int g = 0; g < 8; g++) begin
            a = x[t[g][0]]; b = x[t[g][1]]; c = x[t[g][2]]; d = x[t[g][3]];
            a = a + b; d = rl(d ^ a, 16);
            c = c + d; b = rl(b ^ c, 12);
            a = a + b; d = rl(d ^ a, 8);
            c = c + d; b = rl(b ^ c, 7);
            x[t[g][0]] = a; x[t[g][1]] = b; x[t[g][2]] = c; x[t[g][3]] = d;
         end
      end
      for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + st[32*i +: 32];
      return r;
   endfunction

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // mode 0: in_valid, 1: next_blk, 2: both. Measures latency and result on all three instances.
   task automatic run_block(input logic [511:0] st, input logic [511:0] exp, input int mode,
                            input int exp_wraps, output logic [511:0] out0);
      int           lat [3];
      logic [511:0] got [3];
      bit           seen [3];
      int           wraps;
      int           n;
      wraps = 0;
      for (int k = 0; k < 3; k++) begin lat[k] = 0; got[k] = '0; seen[k] = 1'b0; end
      state_in = st;
      in_valid = (mode != 1);
`ifdef CHACHA_CTR_AUTOINC_EN
      next_blk = (mode != 0);
`endif
      @(posedge clk); #1;
      in_valid = 1'b0;
`ifdef CHACHA_CTR_AUTOINC_EN
      next_blk = 1'b0;
      if (ctr_wrap[0]) wraps++;
`endif
      for (int k = 0; k < 3; k++) chk($sformatf("busy_after_accept_l%0d", 1 << k), 512'(busy[k]), 512'd1);
      n = 0;
      while (!(seen[0] && seen[1] && seen[2]) && n < 200) begin
         @(posedge clk); #1;
         n++;
`ifdef CHACHA_CTR_AUTOINC_EN
         if (ctr_wrap[0]) wraps++;
`endif
         for (int k = 0; k < 3; k++) begin
            if (out_valid[k] && !seen[k]) begin
               seen[k] = 1'b1; lat[k] = n; got[k] = state_out[k];
            end
         end
      end
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("latency_l%0d", 1 << k), 512'(lat[k]), 512'((ROUNDS / 2) * (8 >> k) + 1));
         chk($sformatf("state_out_l%0d", 1 << k), got[k], exp);
      end
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("done_one_cycle_l%0d", 1 << k), 512'(out_valid[k]), 512'd0);
         chk($sformatf("back_idle_l%0d", 1 << k), 512'(in_ready[k]), 512'd1);
      end
`ifdef CHACHA_CTR_AUTOINC_EN
      chk("ctr_wrap_pulses", 512'(wraps), 512'(exp_wraps));
`else
      if (exp_wraps != 0) chk("ctr_wrap_unexpected", 512'(wraps), 512'd0);
`endif
      out0 = got[0];
   endtask

   initial begin
      vec_t         tbl [2];
      logic [511:0] st, exp, o;
      int           outs;

      tbl[0].st = {32'h00000000, 32'h4a000000, 32'h09000000, 32'h00000001,
                   32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
                   32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100,
                   32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
      tbl[0].w0 = 32'he4e7f110; tbl[0].w1 = 32'h15593bd1;
      tbl[1].st = {384'd0, 32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
      tbl[1].w0 = 32'hade0b876; tbl[1].w1 = 32'h903df1a0;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; state_in = '0;
`ifdef CHACHA_CTR_AUTOINC_EN
      next_blk = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_in_ready_l%0d", 1 << k), 512'(in_ready[k]), 512'd1);
         chk($sformatf("rst_out_valid_l%0d", 1 << k), 512'(out_valid[k]), 512'd0);
         chk($sformatf("rst_busy_l%0d", 1 << k), 512'(busy[k]), 512'd0);
         chk($sformatf("rst_state_out_l%0d", 1 << k), state_out[k], 512'd0);
      end
      rst_n = 1'b1;

      // Known-answer table; the first accept lands on the first edge after reset release.
      for (int v = 0; v < 2; v++) begin
         run_block(tbl[v].st, chacha_ref(tbl[v].st), 0, 0, o);
         chk($sformatf("kat%0d_word0", v), 512'(o[31:0]), 512'(tbl[v].w0));
         chk($sformatf("kat%0d_word1", v), 512'(o[63:32]), 512'(tbl[v].w1));
      end

      for (int v = 0; v < 4; v++) begin
         for (int i = 0; i < 16; i++) st[32*i +: 32] = $urandom;
         run_block(st, chacha_ref(st), 0, 0, o);
      end

      // Backpressure: hold DONE for 10 cycles; in_valid pulses while busy are ignored.
      st = tbl[0].st; exp = chacha_ref(st);
      out_ready = 1'b0; state_in = st; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int n = 1; n <= 81; n++) begin
         @(posedge clk); #1;
         in_valid = (n == 5) || (n == 12) || (n == 30);
         state_in = ~st;
      end
      in_valid = 1'b0;
      chk("bp_valid_rise", 512'(out_valid[0]), 512'd1);
      for (int n = 0; n < 10; n++) begin
         @(posedge clk); #1;
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_hold_valid_l%0d", 1 << k), 512'(out_valid[k]), 512'd1);
            chk($sformatf("bp_hold_data_l%0d", 1 << k), state_out[k], exp);
         end
      end
      out_ready = 1'b1;
      outs = out_valid[0] ? 1 : 0;
      for (int n = 0; n < 90; n++) begin
         @(posedge clk); #1;
         if (out_valid[0]) outs++;
      end
      chk("bp_output_count", 512'(outs), 512'd1);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("bp_held_after_l%0d", 1 << k), state_out[k], exp);
         chk($sformatf("bp_idle_after_l%0d", 1 << k), 512'(busy[k]), 512'd0);
      end

      // Reset 30 cycles into a block: immediate clear, no output after release.
      state_in = tbl[1].st; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("midrst_busy_l%0d", 1 << k), 512'(busy[k]), 512'd0);
         chk($sformatf("midrst_state_out_l%0d", 1 << k), state_out[k], 512'd0);
         chk($sformatf("midrst_in_ready_l%0d", 1 << k), 512'(in_ready[k]), 512'd1);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      outs = 0;
      for (int n = 0; n < 120; n++) begin
         @(posedge clk); #1;
         if (out_valid != 3'b000) outs++;
      end
      chk("midrst_no_output", 512'(outs), 512'd0);

      for (int i = 0; i < 16; i++) st[32*i +: 32] = $urandom;
      run_block(st, chacha_ref(st), 0, 0, o);

`ifdef CHACHA_CTR_AUTOINC_EN
      // Counter auto-increment with rollover, then in_valid winning over next_blk.
      st = tbl[0].st; st[12*32 +: 32] = 32'hFFFF_FFFF;
      run_block(st, chacha_ref(st), 0, 0, o);
      st[12*32 +: 32] = 32'd0;
      run_block(st, chacha_ref(st), 1, 1, o);
      st[12*32 +: 32] = 32'd0;
      st[12*32 +: 32] = 32'd1;
      run_block(st, chacha_ref(st), 1, 0, o);
      st = tbl[1].st;
      run_block(st, chacha_ref(st), 2, 0, o);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
